// File: rtl/cache_arb_pkg.sv
// Shared types and constants for the cache port arbiter and its round-robin picker.
package cache_arb_pkg;

    localparam int ADDR_W  = 64;
    localparam int DATA_W  = 64;
    localparam int MAX_REQ = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_t;

    // Index width for n requesters; never below 1 so a 1-bit pointer still exists.
    function automatic int idx_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first valid index at or after ptr, wrapping.
module rr_picker #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     valid,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;

    // Scan offsets from farthest to nearest so the nearest valid candidate wins last.
    always_comb begin
        grant = '0;
        idx   = '0;
        sum   = '0;
        cand  = '0;
        for (int k = N - 1; k >= 0; k--) begin
            sum = {1'b0, ptr} + (IDX_W + 1)'(k);
            if (sum >= (IDX_W + 1)'(N)) sum = sum - (IDX_W + 1)'(N);
            cand = sum[IDX_W-1:0];
            if (valid[cand]) begin
                grant       = '0;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/cache_port_arbiter.sv
// Shares the single cache port between NUM_REQ requesters: accept, issue one strobe, return response.
module cache_port_arbiter
    import cache_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int CNT_W   = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        resp_valid,
    output logic [DATA_W-1:0]         resp_rdata,
    output logic                      resp_miss,
    output logic                      mem_read,
    output logic                      mem_write,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic [DATA_W-1:0]         mem_rdata,
    input  logic                      mem_miss,
    output logic                      busy,
    output logic [CNT_W-1:0]          miss_count,
    output logic [CNT_W-1:0]          access_count
);

    localparam int IDX_W = idx_width(NUM_REQ);

    arb_state_t         state, state_nxt;
    logic [IDX_W-1:0]   rr_ptr, cap_idx, pick_idx;
    logic [NUM_REQ-1:0] pick_grant;
    logic               cap_write;
    logic [ADDR_W-1:0]  cap_addr;
    logic [DATA_W-1:0]  cap_wdata;
    logic               accept;

    rr_picker #(.N(NUM_REQ), .IDX_W(IDX_W)) u_pick (
        .valid (req_valid),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .idx   (pick_idx)
    );

    // The cache sees the captured request; these hold between accesses.
    assign mem_addr  = cap_addr;
    assign mem_wdata = cap_wdata;
    assign busy      = (state != IDLE);

    // Next-state and per-state outputs; everything idles at zero outside its own state.
    always_comb begin
        state_nxt  = state;
        req_ready  = '0;
        resp_valid = '0;
        resp_rdata = '0;
        resp_miss  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                req_ready = pick_grant;
                accept    = |req_valid;
                if (accept) state_nxt = ISSUE;
            end
            ISSUE: begin
                mem_read  = !cap_write;
                mem_write = cap_write;
                state_nxt = RESP;
            end
            RESP: begin
                resp_valid[cap_idx] = 1'b1;
                resp_rdata          = mem_rdata;
                resp_miss           = mem_miss && !cap_write;
                state_nxt           = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Capture the winning request and advance the pointer past it on each accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr    <= '0;
            cap_idx   <= '0;
            cap_write <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
        end else if (accept) begin
            cap_idx   <= pick_idx;
            cap_write <= req_write[pick_idx];
            cap_addr  <= req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
            cap_wdata <= req_wdata[int'(pick_idx)*DATA_W +: DATA_W];
            rr_ptr    <= (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);
        end
    end

    // Saturating statistics: accesses counted at issue, misses at response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            access_count <= '0;
            miss_count   <= '0;
        end else begin
            if (state == ISSUE && access_count != '1)
                access_count <= access_count + CNT_W'(1);
            if (resp_miss && miss_count != '1)
                miss_count <= miss_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Scoreboard bench for cache_port_arbiter with a behavioural cache and request-level reference model.
module tb_cache_port_arbiter;

    localparam int N    = 3;
    localparam int CW   = 4;
    localparam int MAXC = (1 << CW) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [N-1:0]      req_valid = '0, req_write = '0;
    logic [N*64-1:0]   req_addr = '0, req_wdata = '0;
    logic [N-1:0]      req_ready, resp_valid;
    logic [63:0]       resp_rdata, mem_addr, mem_wdata;
    logic [63:0]       mem_rdata = '0;
    logic              mem_miss = 1'b0;
    logic              resp_miss, mem_read, mem_write, busy;
    logic [CW-1:0]     miss_count, access_count;

    cache_port_arbiter #(.NUM_REQ(N), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_miss(resp_miss),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_miss(mem_miss), .busy(busy),
        .miss_count(miss_count), .access_count(access_count)
    );

    initial forever #5 clk = ~clk;

    int tcyc = 0;
    always @(posedge clk) tcyc <= tcyc + 1;

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, tcyc);
    endtask

    // Behavioural cache: registered outputs, miss allocates a zero line, write allocates.
    logic [63:0] cmem [logic [63:0]];
    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            mem_rdata <= '0;
            mem_miss  <= 1'b0;
            cmem.delete();
        end else if (mem_read) begin
            if (cmem.exists(mem_addr)) begin
                mem_rdata <= cmem[mem_addr];
                mem_miss  <= 1'b0;
            end else begin
                mem_rdata <= '0;
                mem_miss  <= 1'b1;
                cmem[mem_addr] = '0;
            end
        end else if (mem_write) begin
            cmem[mem_addr] = mem_wdata;
            mem_miss <= 1'b0;
        end
    end

    // Reference model state: request-level view of the port.
    typedef struct {
        int          idx;
        logic        w;
        logic [63:0] rdata;
        logic        miss;
        int          due;
        int          acc;
        int          miss_before;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] ref_mem [logic [63:0]];
    int          rr = 0, next_free = 0, issue_cyc = -1, acc_n = 0, miss_n = 0;
    logic        iss_w = 1'b0;
    logic [63:0] iss_a = '0, iss_d = '0;
    logic [N-1:0] hs = '0;

    logic [N-1:0] d_valid = '0, d_write = '0;
    logic [63:0]  d_addr [N];
    logic [63:0]  d_wdata [N];
    logic         d_rst = 1'b1;

    task automatic model_reset();
        rr = 0; next_free = 0; issue_cyc = -1; acc_n = 0; miss_n = 0;
        ref_mem.delete();
        sb.delete();
    endtask

    // Predict the coming edge from the current inputs and check the cycle's outputs.
    task automatic model_cycle();
        int k, win;
        logic [N-1:0] exp_rdy;
        logic [63:0] a;
        exp_t e;
        k = tcyc; win = -1; exp_rdy = '0;
        if (!d_rst && k >= next_free)
            for (int o = 0; o < N; o++)
                if (win < 0 && req_valid[(rr + o) % N]) win = (rr + o) % N;
        if (win >= 0) exp_rdy[win] = 1'b1;
        chk("req_ready", req_ready, exp_rdy);
        chk("busy", busy, !d_rst && k < next_free);
        chk("mem_read", mem_read, !d_rst && k == issue_cyc && !iss_w);
        chk("mem_write", mem_write, !d_rst && k == issue_cyc && iss_w);
        if (!d_rst && k == issue_cyc) begin
            chk("mem_addr", mem_addr, iss_a);
            if (iss_w) chk("mem_wdata", mem_wdata, iss_d);
        end
        if (win >= 0) begin
            a = d_addr[win];
            e.idx = win; e.w = req_write[win]; e.miss_before = miss_n;
            if (e.w) begin
                ref_mem[a] = d_wdata[win]; e.rdata = '0; e.miss = 1'b0;
            end else if (ref_mem.exists(a)) begin
                e.rdata = ref_mem[a]; e.miss = 1'b0;
            end else begin
                e.rdata = '0; e.miss = 1'b1; ref_mem[a] = '0;
            end
            if (acc_n < MAXC) acc_n++;
            e.acc = acc_n;
            if (e.miss && miss_n < MAXC) miss_n++;
            e.due = k + 2;
            sb.push_back(e);
            rr = (win + 1) % N; next_free = k + 3; issue_cyc = k + 1;
            iss_w = e.w; iss_a = a; iss_d = d_wdata[win];
        end
        hs = req_valid & req_ready;
    endtask

    task automatic step();
        @(negedge clk);
        rst = d_rst; req_valid = d_valid; req_write = d_write;
        for (int i = 0; i < N; i++) begin
            req_addr[i*64 +: 64]  = d_addr[i];
            req_wdata[i*64 +: 64] = d_wdata[i];
        end
        #1;
        model_cycle();
    endtask

    task automatic wait_hs(input int i);
        int n;
        n = 0;
        step();
        while (!hs[i] && n < 30) begin step(); n++; end
        if (!hs[i]) chk("grant_timeout", hs, N'(1) << i);
    endtask

    task automatic do_op(input int i, input logic w, input logic [63:0] a, input logic [63:0] d);
        d_valid[i] = 1'b1; d_write[i] = w; d_addr[i] = a; d_wdata[i] = d;
        wait_hs(i);
        d_valid[i] = 1'b0;
        repeat (3) step();
    endtask

    // Monitor: pop and compare whenever a response appears.
    exp_t me;
    initial forever begin
        @(negedge clk);
        #2;
        if (resp_valid != '0) begin
            if (sb.size() == 0) chk("resp_unexpected", resp_valid, '0);
            else begin
                me = sb.pop_front();
                chk("resp_valid", resp_valid, N'(1) << me.idx);
                chk("resp_latency", tcyc, me.due);
                if (!me.w) chk("resp_rdata", resp_rdata, me.rdata);
                chk("resp_miss", resp_miss, me.miss);
                chk("access_count", access_count, me.acc);
                chk("miss_count", miss_count, me.miss_before);
            end
        end else if (sb.size() != 0 && sb[0].due <= tcyc) begin
            me = sb.pop_front();
            chk("resp_missing", resp_valid, N'(1) << me.idx);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int order[$];

    initial begin
        for (int i = 0; i < N; i++) begin d_addr[i] = '0; d_wdata[i] = '0; end
        #1 rst = 1'b1;
        #1;
        chk("rst_req_ready", req_ready, '0);
        chk("rst_resp_valid", resp_valid, '0);
        chk("rst_resp_rdata", resp_rdata, '0);
        chk("rst_mem_strobes", {mem_read, mem_write}, '0);
        chk("rst_mem_addr", mem_addr, '0);
        chk("rst_busy", busy, '0);
        chk("rst_counters", {miss_count, access_count}, '0);
        repeat (2) step();
        d_rst = 1'b0; model_reset();
        step();

        // Cold read miss on requester 1.
        do_op(1, 1'b0, 64'h1000, '0);
        chk("cold_miss_count", miss_count, 1);
        chk("cold_access_count", access_count, 1);

        // Write path then read-back.
        do_op(1, 1'b1, 64'h8, 64'h55);
        do_op(0, 1'b0, 64'h8, '0);

        // Single read after a prior write.
        do_op(0, 1'b1, 64'h40, 64'hDEAD);
        do_op(0, 1'b0, 64'h40, '0);
        do_op(2, 1'b0, 64'h40, '0);

        // Fairness: two requesters held valid for 12 cycles.
        d_valid = 3'b011; d_write = '0; d_addr[0] = 64'h40; d_addr[1] = 64'h8;
        repeat (12) begin
            step();
            for (int i = 0; i < N; i++) if (hs[i]) order.push_back(i);
        end
        d_valid = '0;
        repeat (3) step();
        chk("fair_grants", order.size(), 4);
        for (int j = 0; j < order.size() && j < 4; j++) chk("fair_order", order[j], j % 2);

        // Randomized traffic with withdrawals.
        repeat (400) begin
            for (int i = 0; i < N; i++) begin
                if (hs[i] || !d_valid[i]) begin
                    d_valid[i] = hs[i] ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 2) == 0);
                    d_write[i] = 1'($urandom_range(0, 1));
                    d_addr[i]  = 64'($urandom_range(0, 15)) << 3;
                    d_wdata[i] = {$urandom, $urandom};
                end else if ($urandom_range(0, 15) == 0) begin
                    d_valid[i] = 1'b0;
                end
            end
            step();
        end
        d_valid = '0;
        repeat (4) step();

        // Reset during ISSUE drops the access.
        d_valid[0] = 1'b1; d_write[0] = 1'b0; d_addr[0] = 64'h2000;
        wait_hs(0);
        d_valid[0] = 1'b0;
        step();
        #2;
        rst = 1'b1; d_rst = 1'b1;
        #1;
        chk("midrst_strobes", {mem_read, mem_write}, '0);
        chk("midrst_busy", busy, '0);
        chk("midrst_resp", {resp_valid, resp_miss}, '0);
        chk("midrst_rdata", resp_rdata, '0);
        chk("midrst_addr", mem_addr, '0);
        chk("midrst_counters", {miss_count, access_count}, '0);
        model_reset();
        repeat (2) step();
        d_rst = 1'b0;
        d_valid = 3'b011; d_addr[0] = 64'h3000; d_addr[1] = 64'h3008;
        step();
        chk("post_rst_grant", hs, 3'b001);
        d_valid[0] = 1'b0;
        wait_hs(1);
        d_valid = '0;
        repeat (3) step();

        // Counter saturation with 17 fresh-address misses.
        for (int j = 0; j < 17; j++) do_op(2, 1'b0, 64'h10000 + 64'(j) * 8, '0);
        chk("sat_miss_count", miss_count, 4'hF);
        chk("sat_access_count", access_count, 4'hF);

        repeat (3) step();
        chk("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/cache_port_arbiter.md
# cache_port_arbiter

Sequencing controller that shares the single port of the two-level cache hierarchy between `NUM_REQ` requesters (instruction fetch, load/store unit, debug/DMA). It accepts one request at a time with a round-robin grant, drives the cache's `mem_read`/`mem_write` strobes for exactly one cycle, and returns the registered cache response (`read_data`, `miss`) to the winning requester. It sits between the core-side requesters and `cache_hierarchy`, and it also exports a miss counter to the performance counter.

## Interface
- `NUM_REQ`, 2: number of requesters (2..4).
- `CNT_W`, 32: width of the miss and access counters.

Ports, clock and reset first:
- `clk` in 1: single clock; all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in NUM_REQ: per-requester request pending.
- `req_write` in NUM_REQ: 1 = write, 0 = read.
- `req_addr` in NUM_REQ*64: packed addresses; requester i is at [64i+63:64i].
- `req_wdata` in NUM_REQ*64: packed write data.
- `req_ready` out NUM_REQ: one-hot grant/accept.
- `resp_valid` out NUM_REQ: one-hot response strobe.
- `resp_rdata` out 64: read data, shared by all requesters.
- `resp_miss` out 1: cache miss flag for the response.
- `mem_read`, `mem_write` out 1: cache strobes.
- `mem_addr`, `mem_wdata` out 64: cache address and write data.
- `mem_rdata` in 64, `mem_miss` in 1: cache outputs, registered inside the cache.
- `busy` out 1: FSM not in IDLE.
- `miss_count`, `access_count` out CNT_W: saturating statistics.

## Operation
- FSM states:
  - IDLE: at least one `req_valid` -> set `req_ready` for the round-robin winner (combinational). The handshake completes on the edge where valid&&ready are both high; capture index, write, addr and wdata, then go to ISSUE.
  - ISSUE: drive `mem_read` = !write or `mem_write` = write, plus `mem_addr`/`mem_wdata` from the captured registers -> RESP.
  - RESP: `resp_valid[idx]`=1, `resp_rdata`=`mem_rdata`, `resp_miss`=`mem_miss`&&!write -> IDLE.
- Writes also get a RESP cycle: rdata is don't-care and miss=0.
- Round robin: `rr_ptr` holds the last granted index plus 1, modulo NUM_REQ. The winner is the first valid index at or after `rr_ptr`, wrapping. `rr_ptr` updates only on an accepted handshake.
- Requesters hold `req_*` stable while valid && !ready. `req_valid` deasserting before grant withdraws the request with no side effects.
- `req_ready` is 0 in ISSUE and RESP. A requester's new `req_valid` during its own RESP cycle is eligible in the next IDLE.
- `access_count` increments on each ISSUE. `miss_count` increments in RESP when `resp_miss`=1. Both counters saturate at all-ones and do not wrap.
- All `mem_*` strobes are 0 outside ISSUE. `mem_addr`/`mem_wdata` hold their last value.

## Timing
- Reset values:
  - state=IDLE, `rr_ptr`=0, captured regs=0.
  - `req_ready`=0 when no valid, `resp_valid`=0, `resp_rdata`=0, `resp_miss`=0.
  - `mem_read`=`mem_write`=0, `mem_addr`=`mem_wdata`=0.
  - `busy`=0, counters=0.
- Latency: handshake edge T, ISSUE in cycle T+1, `resp_valid` in cycle T+2. Throughput is one access per 3 cycles.
- Reset asserted mid-operation: the in-flight access is dropped with no `resp_valid`, and outputs return to reset values immediately (asynchronous). A cache strobe cut short by reset is tolerated because the cache is reset concurrently.
- No `req_valid` in IDLE: stay in IDLE, `busy`=0, no strobes.
- Simultaneous valids at reset: requester 0 wins.
- `rr_ptr` wraps from NUM_REQ-1 to 0.

## Structure
- Shared package `cache_arb_pkg`:
  - state enum (IDLE/ISSUE/RESP, 2-bit encoding),
  - `ADDR_W`=64, `DATA_W`=64,
  - `MAX_REQ`=4,
  - function to compute `clog2(NUM_REQ)` index width.
- Sub-module `rr_picker`: purely combinational. Inputs are the valid vector and `rr_ptr`; outputs are the one-hot grant and the encoded index. It is reused by other shared-resource arbiters.
- Top-level `cache_port_arbiter` holds the FSM, capture registers, counters and output muxing.

## Test plan
- Single read: req0 valid, addr=0x40 after a prior write of 0xDEAD to 0x40 -> `mem_read` one cycle at T+1; `resp_valid`=01, rdata=0xDEAD, miss=0 at T+2.
- Cold read miss: req1 reads 0x1000 after reset -> `resp_valid`=10, miss=1, rdata=0; `miss_count`=1, `access_count`=1.
- Fairness: both requesters hold valid for 12 cycles -> grant order is 0,1,0,1; each receives 2 responses; no two `resp_valid` bits are ever set together.
- Write path: req1 writes 0x55 to 0x8 -> `mem_write`=1 for exactly one cycle with `mem_wdata`=0x55; `resp_valid`=10 with miss=0; a following req0 read of 0x8 returns 0x55.
- Reset mid-access: assert `rst` during ISSUE -> no `resp_valid`; all outputs are 0 the same cycle; after release, a req1 request is granted before req0 only if req0 is not valid (`rr_ptr`=0).
- Counter saturation (`CNT_W`=4): 17 misses -> `miss_count` holds 0xF.
